// File: rtl/stack_access_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : stack_access_seq_if
// Description : Bundle of decoder request, stack pointer controller, data
//               memory byte port and result signals around stack_access_seq.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
interface stack_access_seq_if;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_code;
  logic [15:0] push_data;
  logic [15:0] ret_pc;
  logic [15:0] call_target;
  logic [7:0]  stack_pointer;
  logic        stack_command;
  logic [1:0]  stack_ctl;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [15:0] pop_data;
  logic        pop_valid;
  logic        pc_load;
  logic [15:0] pc_target;
  logic        overflow;
  logic        underflow;

  // Environment side: decoder, pointer controller and memory.
  modport master (
    output op_valid, op_code, push_data, ret_pc, call_target,
    output stack_pointer, mem_rdata,
    input  op_ready, stack_command, stack_ctl, mem_addr, mem_we, mem_re,
    input  mem_wdata, pop_data, pop_valid, pc_load, pc_target,
    input  overflow, underflow
  );

  // Sequencer side.
  modport slave (
    input  op_valid, op_code, push_data, ret_pc, call_target,
    input  stack_pointer, mem_rdata,
    output op_ready, stack_command, stack_ctl, mem_addr, mem_we, mem_re,
    output mem_wdata, pop_data, pop_valid, pc_load, pc_target,
    output overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/stack_access_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : stack_access_seq
// Description : Executes PUSH/POP/CALL/RETURN as two byte accesses to data
//               memory, strobing the external stack pointer controller.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module stack_access_seq #(
  parameter logic [7:0] STACK_BASE = 8'h3E,
  parameter logic [7:0] STACK_TOP  = 8'hFC
) (
  input wire logic          clk,
  input wire logic          rst,
  stack_access_seq_if.slave bus
);

  localparam logic [1:0] c_op_push = 2'd0;
  localparam logic [1:0] c_op_pop  = 2'd1;
  localparam logic [1:0] c_op_call = 2'd2;

  localparam logic [3:0] c_st_idle   = 4'd0;
  localparam logic [3:0] c_st_wr_lo  = 4'd1;
  localparam logic [3:0] c_st_wr_hi  = 4'd2;
  localparam logic [3:0] c_st_cmd_hi = 4'd3;
  localparam logic [3:0] c_st_cmd_lo = 4'd4;
  localparam logic [3:0] c_st_rd_lo  = 4'd5;
  localparam logic [3:0] c_st_rd_hi  = 4'd6;
  localparam logic [3:0] c_st_rd_cap = 4'd7;
  localparam logic [3:0] c_st_done   = 4'd8;
  localparam logic [3:0] c_st_err    = 4'd9;

  logic [3:0]  r_state, w_next;
  logic [1:0]  r_code;
  logic [15:0] r_word, r_target;
  logic [7:0]  r_lo;
  logic        r_op_ready, r_cmd, r_we, r_re, r_pop_valid, r_pc_load;
  logic        r_ovf, r_udf;
  logic [7:0]  r_addr, r_wdata;
  logic [15:0] r_pop_data, r_pc_target;

  logic        w_op_ready_nx, w_cmd_nx, w_we_nx, w_re_nx, w_pop_valid_nx;
  logic        w_pc_load_nx, w_ovf_nx, w_udf_nx;
  logic [7:0]  w_addr_nx, w_wdata_nx, w_lo_nx;
  logic [15:0] w_pop_data_nx, w_pc_target_nx;

  // op_ready is only ever high while in IDLE, so this is the accept strobe.
  wire logic        w_accept   = bus.op_valid & r_op_ready;
  // PUSH and CALL both have bit 0 clear; they are the memory-writing ops.
  wire logic        w_in_write = ~bus.op_code[0];
  wire logic        w_ovf_hit  = bus.stack_pointer > STACK_TOP;
  wire logic        w_udf_hit  = bus.stack_pointer <= STACK_BASE;
  wire logic [15:0] w_word_in  = (bus.op_code == c_op_call) ? bus.ret_pc : bus.push_data;
  wire logic [7:0]  w_sp_inc   = bus.stack_pointer + 8'd1;

  // State register plus registered outputs and operand latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_st_idle;
      r_code      <= 2'd0;
      r_word      <= 16'd0;
      r_target    <= 16'd0;
      r_lo        <= 8'd0;
      r_op_ready  <= 1'b0;
      r_cmd       <= 1'b0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_addr      <= 8'd0;
      r_wdata     <= 8'd0;
      r_pop_data  <= 16'd0;
      r_pop_valid <= 1'b0;
      r_pc_load   <= 1'b0;
      r_pc_target <= 16'd0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else begin
      r_state     <= w_next;
      if (w_accept) begin
        r_code   <= bus.op_code;
        r_word   <= w_word_in;
        r_target <= bus.call_target;
      end
      r_lo        <= w_lo_nx;
      r_op_ready  <= w_op_ready_nx;
      r_cmd       <= w_cmd_nx;
      r_we        <= w_we_nx;
      r_re        <= w_re_nx;
      r_addr      <= w_addr_nx;
      r_wdata     <= w_wdata_nx;
      r_pop_data  <= w_pop_data_nx;
      r_pop_valid <= w_pop_valid_nx;
      r_pc_load   <= w_pc_load_nx;
      r_pc_target <= w_pc_target_nx;
      r_ovf       <= w_ovf_nx;
      r_udf       <= w_udf_nx;
    end
  end

  // Next-state: range checks happen once, at accept, in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_accept) begin
          if (w_in_write) w_next = w_ovf_hit ? c_st_err : c_st_wr_lo;
          else            w_next = w_udf_hit ? c_st_err : c_st_cmd_hi;
        end
      end
      c_st_wr_lo:  w_next = c_st_wr_hi;
      c_st_wr_hi:  w_next = c_st_cmd_hi;
      c_st_cmd_hi: w_next = c_st_cmd_lo;
      c_st_cmd_lo: w_next = r_code[0] ? c_st_rd_lo : c_st_done;
      c_st_rd_lo:  w_next = c_st_rd_hi;
      c_st_rd_hi:  w_next = c_st_rd_cap;
      c_st_rd_cap: w_next = c_st_done;
      c_st_done:   w_next = c_st_idle;
      c_st_err:    w_next = c_st_idle;
      default:     w_next = c_st_idle;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    w_op_ready_nx  = (w_next == c_st_idle);
    w_cmd_nx       = (w_next == c_st_cmd_hi);
    w_we_nx        = (w_next == c_st_wr_lo) || (w_next == c_st_wr_hi);
    w_re_nx        = (w_next == c_st_rd_lo) || (w_next == c_st_rd_hi);
    w_addr_nx      = r_addr;
    w_wdata_nx     = r_wdata;
    w_lo_nx        = (r_state == c_st_rd_hi) ? bus.mem_rdata : r_lo;
    w_pop_valid_nx = 1'b0;
    w_pop_data_nx  = r_pop_data;
    w_pc_load_nx   = 1'b0;
    w_pc_target_nx = r_pc_target;
    w_ovf_nx       = r_ovf;
    w_udf_nx       = r_udf;
    case (w_next)
      c_st_wr_lo: begin
        w_addr_nx  = bus.stack_pointer;
        w_wdata_nx = w_word_in[7:0];
      end
      c_st_wr_hi: begin
        w_addr_nx  = w_sp_inc;
        w_wdata_nx = r_word[15:8];
      end
      c_st_rd_lo: w_addr_nx = bus.stack_pointer;
      c_st_rd_hi: w_addr_nx = w_sp_inc;
      c_st_err: begin
        if (w_in_write) w_ovf_nx = 1'b1;
        else            w_udf_nx = 1'b1;
      end
      c_st_done: begin
        if (r_state == c_st_rd_cap) begin
          if (r_code == c_op_pop) begin
            w_pop_valid_nx = 1'b1;
            w_pop_data_nx  = {bus.mem_rdata, r_lo};
          end else begin
            w_pc_load_nx   = 1'b1;
            w_pc_target_nx = {bus.mem_rdata, r_lo};
          end
        end else if (r_code == c_op_call) begin
          w_pc_load_nx   = 1'b1;
          w_pc_target_nx = r_target;
        end
      end
      default: ;
    endcase
  end

  assign bus.op_ready      = r_op_ready;
  assign bus.stack_command = r_cmd;
  assign bus.stack_ctl     = r_code;
  assign bus.mem_addr      = r_addr;
  assign bus.mem_we        = r_we;
  assign bus.mem_re        = r_re;
  assign bus.mem_wdata     = r_wdata;
  assign bus.pop_data      = r_pop_data;
  assign bus.pop_valid     = r_pop_valid;
  assign bus.pc_load       = r_pc_load;
  assign bus.pc_target     = r_pc_target;
  assign bus.overflow      = r_ovf;
  assign bus.underflow     = r_udf;

  // Unused in the datapath: the PUSH code is implied by bit 0 being clear.
  wire logic w_unused = &{1'b0, c_op_push};

endmodule
`default_nettype wire

// File: doc/stack_access_seq.md
# stack_access_seq

Sequencer between the instruction decoder and the data memory that executes PUSH, POP, CALL and RETURN. It accepts one stack operation at a time and moves 16-bit words as two byte accesses. It drives the `stack_command`/`stack_ctl` pair consumed by the stack pointer controller, and reads that controller's `stack_pointer` back as its memory address. For CALL/RETURN it also produces the PC-load request for jump control.

## Interface
- `STACK_BASE`, default 8'h3E: stack pointer reset/empty value.
- `STACK_TOP`, default 8'hFC: highest legal pointer at which a push may start.
- `clk`  in  1: system clock.
- `rst`  in  1: reset; one clock, reset synchronous and active-high.
- `op_valid`  in  1: decoder request.
- `op_ready`  out  1: high only in IDLE; accept = `op_valid & op_ready`.
- `op_code`  in  2: 0 PUSH, 1 POP, 2 CALL, 3 RETURN (same encoding as `stack_ctl`).
- `push_data`  in  16: PUSH operand.
- `ret_pc`  in  16: return address stored by CALL.
- `call_target`  in  16: CALL destination.
- `stack_pointer`  in  8: current pointer from the stack pointer controller.
- `stack_command`  out  1: pointer strobe; the pointer increments on its rising edge and decrements on its falling edge.
- `stack_ctl`  out  2: op code presented to the pointer controller.
- `mem_addr`  out  8, `mem_we`  out  1, `mem_re`  out  1, `mem_wdata`  out  8: byte port to data memory.
- `mem_rdata`  in  8: read data, valid the cycle after `mem_re`.
- `pop_data`  out  16, `pop_valid`  out  1: POP result, valid for a 1-cycle pulse.
- `pc_load`  out  1, `pc_target`  out  16: jump request, valid for a 1-cycle pulse.
- `overflow`  out  1, `underflow`  out  1: sticky error flags.

## Operation
- On accept, latch `op_code`, `push_data`, `ret_pc` and `call_target`. `stack_ctl` = latched code and stays stable until the FSM returns to IDLE.
- Word layout: low byte at `sp`, high byte at `sp+1`. Address arithmetic is 8-bit and wraps.
- Write word: `push_data` for PUSH; `ret_pc` for CALL.
- FSM states: IDLE, WR_LO, WR_HI, CMD_HI, CMD_LO, RD_LO, RD_HI, RD_CAP, DONE, ERR.
- PUSH/CALL path: IDLE → WR_LO → WR_HI → CMD_HI → CMD_LO → DONE → IDLE.
  - WR_LO: write the low byte at `stack_pointer`.
  - WR_HI: write the high byte at `stack_pointer+1`.
  - CMD_HI: `stack_command`=1, so the pointer increments by 2.
  - CMD_LO: `stack_command`=0.
  - DONE: for CALL, `pc_load`=1 with `pc_target`=`call_target`. PUSH has no pulse.
- POP/RETURN path: IDLE → CMD_HI → CMD_LO → RD_LO → RD_HI → RD_CAP → DONE → IDLE.
  - CMD_LO: the falling edge of `stack_command` decrements the pointer.
  - RD_LO: `mem_re` at the new `stack_pointer`.
  - RD_HI: `mem_re` at `stack_pointer+1`; capture the low byte.
  - RD_CAP: capture the high byte.
  - DONE: for POP, `pop_valid`=1 with `pop_data`={hi,lo}. For RETURN, `pc_load`=1 with `pc_target`={hi,lo}.
- Overflow check, in IDLE at accept: PUSH/CALL with `stack_pointer` > `STACK_TOP` goes to ERR. Set `overflow`, do no memory write and no `stack_command` edge.
- Underflow check, in IDLE at accept: POP/RETURN with `stack_pointer` <= `STACK_BASE` goes to ERR. Set `underflow`; no read, no strobe, no `pop_valid`/`pc_load`.
- ERR lasts 1 cycle, then IDLE.
- Flags are cleared only by `rst`.
- `mem_we`/`mem_re` are never high together, and never high outside the WR_*/RD_* states.

## Timing
- Accept at edge N; the FSM enters its first state at N+1.
- PUSH: writes at N+1 and N+2, `stack_command` high during N+3, DONE at N+5, `op_ready` again at N+6.
- CALL: same as PUSH, with `pc_load` at N+5.
- POP/RETURN: strobe high during N+1, reads issued at N+3 and N+4, result pulse at N+6, `op_ready` at N+7.
- Error: ERR at N+1, `op_ready` at N+2; the flag is visible from N+1.
- All outputs are registered.
- Reset values: `op_ready`=0 in the reset cycle and 1 after. All of the following are 0: `stack_command`, `stack_ctl`, `mem_*`, `pop_data`, `pop_valid`, `pc_load`, `pc_target`, `overflow`, `underflow`.
- Reset mid-operation: abort to IDLE with no further memory cycles. `stack_ctl` goes to 0 in the same edge that drops `stack_command`, so a falling strobe cannot decrement the pointer.
- `op_valid` outside IDLE is ignored, not queued.

## Test plan
- Reset, `sp`=3E, PUSH 0xBEEF → mem[3E]=EF, mem[3F]=BE, strobe pulse at N+3, `sp`=40, `op_ready` at N+6.
- Then POP → `sp`=3E, reads 3E/3F, `pop_data`=BEEF with `pop_valid` at N+6, no `pc_load`.
- CALL `ret_pc`=0x0123, `call_target`=0x0200 → mem[3E]=23, mem[3F]=01, `pc_load` with `pc_target`=0200. Then RETURN → `pc_target`=0123.
- POP at `sp`=3E → `underflow`=1, no `mem_re`, no strobe edge, `op_ready` at N+2. The flag stays set through later legal ops until `rst`.
- PUSH at `sp`=FE → `overflow`=1, no `mem_we`. PUSH at `sp`=FC → succeeds, writing FC/FD.
- `rst` during CMD_HI of a POP → `stack_command` and `stack_ctl` both 0 next cycle, `sp` unchanged, no read, IDLE.
